// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: stall-vector bit positions, the four legal
// stall patterns, and the multi-cycle FSM state encoding.
package pipeline_ctrl_pkg;

  // Bit positions inside the 6-bit stage hold vector.
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;
  localparam int unsigned STALL_W = 6;

  // The only values the stall vector may ever take.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  // Multi-cycle FSM encoding.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_MC_BUSY = 1'b1;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard/multi-cycle/memory status from the datapath
// toward the controller, and the stall/flush/busy controls back.
//   master : datapath side (drives status, receives controls)
//   slave  : pipeline_ctrl side
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int REG_W    = 5
);
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic                ex_mem_read;
  logic [REG_W-1:0]    ex_rd;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                mem_stallreq;
  logic                branch_taken;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic                mc_busy;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rd, ex_mc_start, ex_mc_cycles,
           mem_stallreq, branch_taken,
    input  stall, flush, mc_busy
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rd, ex_mc_start, ex_mc_cycles,
           mem_stallreq, branch_taken,
    output stall, flush, mc_busy
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination (non-zero)
// is a source of the instruction currently in ID.
//   ex_mem_read, ex_rd : load flag and destination of the EX instruction
//   id_rs, id_rt       : sources of the ID instruction
//   load_use           : hazard present
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);
  // Register 0 is hard-wired, so a load into it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller.
//   clk, reset : clock and synchronous active-high reset
//   bus        : status inputs (load-use operands, multi-cycle start,
//                memory stall, taken branch) and control outputs
//                (stall vector, flush, mc_busy)
// Stall priority: memory > multi-cycle EX > load-use > none.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int REG_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                load_use;
  logic                mc_go;
  logic [STALL_W-1:0]  stall;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .load_use    (load_use)
  );

  // Operations of 0 or 1 cycles complete in the normal EX slot.
  assign mc_go = (state_q == ST_IDLE) && bus.ex_mc_start &&
                 (bus.ex_mc_cycles >= MC_CNT_W'(2));

  always_comb begin
    stall = STALL_NONE;
    if (reset) begin
      stall = STALL_NONE;
    end else if (bus.mem_stallreq) begin
      stall = STALL_MEM;
    end else if ((state_q == ST_MC_BUSY) || mc_go) begin
      stall = STALL_EX;
    end else if (load_use && !bus.branch_taken) begin
      // A taken branch flushes the ID instruction, so its hazard is moot.
      stall = STALL_ID;
    end
  end

  assign bus.stall   = stall;
  // A branch held in EX waits and flushes in the cycle it is released.
  assign bus.flush   = !reset && bus.branch_taken && !stall[STG_EX];
  assign bus.mc_busy = (state_q == ST_MC_BUSY);

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    if (state_q == ST_IDLE) begin
      if (mc_go) begin
        state_d  = ST_MC_BUSY;
        mc_cnt_d = bus.ex_mc_cycles - MC_CNT_W'(1);
      end
    end else begin
      // Counts down regardless of MEM stalls; new starts are ignored.
      if (mc_cnt_q == MC_CNT_W'(1)) begin
        state_d  = ST_IDLE;
        mc_cnt_d = '0;
      end else begin
        mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.MC_CNT_W(6), .REG_W(5)) bus ();

  pipeline_ctrl #(
    .MC_CNT_W (6),
    .REG_W    (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       mr;
    logic       mcs;
    logic [5:0] mcc;
    logic       msr;
    logic       br;
    logic [5:0] e_stall;
    logic       e_flush;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic mr, input logic mcs, input logic [5:0] mcc,
                              input logic msr, input logic br, input logic [5:0] e_stall,
                              input logic e_flush, input logic e_busy);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.mr = mr; v.mcs = mcs; v.mcc = mcc;
    v.msr = msr; v.br = br; v.e_stall = e_stall; v.e_flush = e_flush; v.e_busy = e_busy;
    return v;
  endfunction

  // Idle inputs, expecting no stall, no flush, with the given busy state.
  function automatic vec_t idle(input logic [5:0] e_stall, input logic e_busy);
    return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, e_stall, 1'b0, e_busy);
  endfunction

  function automatic vec_t start(input logic [5:0] cyc, input logic [5:0] e_stall,
                                 input logic e_busy);
    return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, cyc, 1'b0, 1'b0, e_stall, 1'b0, e_busy);
  endfunction

  // Drive one cycle of inputs, check mid-cycle, then advance past the edge.
  task automatic run(input vec_t v, input string nm);
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.ex_rd        = v.rd;
    bus.ex_mem_read  = v.mr;
    bus.ex_mc_start  = v.mcs;
    bus.ex_mc_cycles = v.mcc;
    bus.mem_stallreq = v.msr;
    bus.branch_taken = v.br;
    #2;
    n_tests++;
    if (bus.stall !== v.e_stall) begin
      n_fail++;
      $display("FAIL %s stall: got %b expected %b", nm, bus.stall, v.e_stall);
    end
    n_tests++;
    if (bus.flush !== v.e_flush) begin
      n_fail++;
      $display("FAIL %s flush: got %b expected %b", nm, bus.flush, v.e_flush);
    end
    n_tests++;
    if (bus.mc_busy !== v.e_busy) begin
      n_fail++;
      $display("FAIL %s mc_busy: got %b expected %b", nm, bus.mc_busy, v.e_busy);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  vec_t tbl[16];

  initial begin
    // Single-cycle vectors applied from IDLE.
    //           rs     rt     rd     mr   mcs  mcc   msr  br   stall flush busy
    tbl[0]  = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[1]  = mk(5'd1,  5'd8,  5'd8,  1'b1, 1'b0, 6'd0, 1'b0, 1'b0, SI, 1'b0, 1'b0);
    tbl[2]  = mk(5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[3]  = mk(5'd3,  5'd9,  5'd3,  1'b1, 1'b0, 6'd0, 1'b0, 1'b0, SI, 1'b0, 1'b0);
    tbl[4]  = mk(5'd1,  5'd8,  5'd8,  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[5]  = mk(5'd7,  5'd9,  5'd8,  1'b1, 1'b0, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[6]  = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b1, 1'b0, SM, 1'b0, 1'b0);
    tbl[7]  = mk(5'd1,  5'd8,  5'd8,  1'b1, 1'b0, 6'd0, 1'b1, 1'b0, SM, 1'b0, 1'b0);
    tbl[8]  = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, S0, 1'b1, 1'b0);
    tbl[9]  = mk(5'd1,  5'd8,  5'd8,  1'b1, 1'b0, 6'd0, 1'b0, 1'b1, S0, 1'b1, 1'b0);
    tbl[10] = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b1, 1'b1, SM, 1'b0, 1'b0);
    tbl[11] = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, S0, 1'b1, 1'b0);
    tbl[12] = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 6'd1, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[13] = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[14] = mk(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 6'd0, 1'b0, 1'b0, S0, 1'b0, 1'b0);
    tbl[15] = mk(5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, SI, 1'b0, 1'b0);

    // Reset with hostile inputs: outputs forced quiet.
    reset = 1'b1;
    bus.id_rs = 5'd8; bus.id_rt = 5'd8; bus.ex_rd = 5'd8; bus.ex_mem_read = 1'b1;
    bus.ex_mc_start = 1'b1; bus.ex_mc_cycles = 6'd4; bus.mem_stallreq = 1'b1;
    bus.branch_taken = 1'b1;
    @(posedge clk);
    #1;
    run(mk(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 6'd4, 1'b1, 1'b1, S0, 1'b0, 1'b0), "reset_hold");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Four-cycle operation: EX stall for 4 cycles, busy for the last 3.
    run(start(6'd4, SE, 1'b0), "mc4_c0");
    run(idle(SE, 1'b1), "mc4_c1");
    run(idle(SE, 1'b1), "mc4_c2");
    run(idle(SE, 1'b1), "mc4_c3");
    run(idle(S0, 1'b0), "mc4_c4");

    // A restart while busy must not extend the count.
    run(start(6'd3, SE, 1'b0), "mc3_c0");
    run(start(6'd9, SE, 1'b1), "mc3_restart");
    run(idle(SE, 1'b1), "mc3_c2");
    run(idle(S0, 1'b0), "mc3_done");
    run(idle(S0, 1'b0), "mc3_after");

    // Memory stall overrides mid-operation; counter keeps running.
    run(start(6'd5, SE, 1'b0), "mc5_c0");
    run(idle(SE, 1'b1), "mc5_c1");
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, SM, 1'b0, 1'b1), "mc5_mem_c2");
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, SM, 1'b0, 1'b1), "mc5_mem_c3");
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, SE, 1'b0, 1'b1), "mc5_br_held");
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, S0, 1'b1, 1'b0), "mc5_br_release");

    // Branch held by MEM, flushed when MEM releases.
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, SM, 1'b0, 1'b0), "br_mem_held");
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, S0, 1'b1, 1'b0), "br_mem_release");

    // Branch alongside a multi-cycle start is held too.
    run(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1, SE, 1'b0, 1'b0), "br_mc_start");
    run(idle(SE, 1'b1), "mc2_c1");
    run(idle(S0, 1'b0), "mc2_done");

    // Reset in the middle of an operation with mc_cnt=5.
    run(start(6'd6, SE, 1'b0), "rst_mc_c0");
    reset = 1'b1;
    run(mk(5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, S0, 1'b0, 1'b1), "rst_mid");
    reset = 1'b0;
    run(idle(S0, 1'b0), "rst_after");
    run(idle(S0, 1'b0), "rst_after2");
    run(tbl[1], "loaduse_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MC_CNT_W, default 6, width of the multi-cycle latency count.
REQ-002 SHALL have parameter REG_W, default 5, width of register-file addresses.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port id_rs  in  REG_W  source register 1 of the instruction in ID.
REQ-006 SHALL have port id_rt  in  REG_W  source register 2 of the instruction in ID.
REQ-007 SHALL have port ex_mem_read  in  1  the instruction in EX is a load.
REQ-008 SHALL have port ex_rd  in  REG_W  destination register of the instruction in EX.
REQ-009 SHALL have port ex_mc_start  in  1  a one-cycle pulse that starts a multi-cycle EX operation (mul/div).
REQ-010 SHALL have port ex_mc_cycles  in  MC_CNT_W  total EX cycles of the started operation, sampled with ex_mc_start.
REQ-011 SHALL have port mem_stallreq  in  1  data memory not ready.
REQ-012 SHALL have port branch_taken  in  1  a taken branch/jump resolved in EX.
REQ-013 SHALL have port stall  out  6  stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. Register k holds when stall[k]=1 and stall[k+1]=1, inserts a bubble when stall[k]=1 and stall[k+1]=0, and loads when stall[k]=0.
REQ-014 SHALL have port flush  out  1  clears the IF/ID and ID/EX registers this cycle.
REQ-015 SHALL have port mc_busy  out  1  a multi-cycle operation is in progress.

Function
REQ-016 The FSM SHALL have two states, IDLE and MC_BUSY, with a down-counter mc_cnt of width MC_CNT_W.
REQ-017 In IDLE, ex_mc_start with ex_mc_cycles>=2 SHALL load mc_cnt=ex_mc_cycles-1 and enter MC_BUSY on the next edge.
REQ-018 ex_mc_start with ex_mc_cycles of 0 or 1 SHALL cause no state change and no stall.
REQ-019 In MC_BUSY, mc_cnt SHALL decrement every cycle, including cycles stalled by MEM.
REQ-020 The FSM SHALL return to IDLE on the edge where mc_cnt=1.
REQ-021 ex_mc_start while in MC_BUSY SHALL be ignored.
REQ-022 mc_busy SHALL equal (state==MC_BUSY).
REQ-023 Load-use hazard SHALL equal ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || ex_rd==id_rt).
REQ-024 stall SHALL be combinational from the current state and inputs, with zero-cycle latency, using this priority:
  - mem_stallreq -> 6'b011111
  - else in MC_BUSY, or in IDLE with ex_mc_start and ex_mc_cycles>=2 -> 6'b001111
  - else load-use -> 6'b000111
  - else 6'b000000
REQ-025 flush SHALL equal branch_taken && !stall[3]; a branch held in EX is flushed in the cycle it is released.
REQ-026 When flush=1 and a load-use hazard also exists, flush SHALL win and stall SHALL be 6'b000000.
REQ-027 stall SHALL never take a value other than the four listed in REQ-024.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=IDLE and mc_cnt=0, overriding any in-progress operation.
REQ-029 While reset=1, stall SHALL be 0 and flush SHALL be 0, regardless of inputs.
REQ-030 mc_busy SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-031 A shared pipeline package SHALL hold:
  - the stall-vector bit indices (STG_PC..STG_WB)
  - the constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM
  - the FSM state encoding
REQ-032 The load-use comparator SHALL be a sub-module named hazard_detect; the FSM, counter and priority logic SHALL live in pipeline_ctrl.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=8, id_rt=8 -> stall=000111 for exactly that cycle; with ex_rd=0 -> stall=000000.
REQ-034 Multi-cycle: ex_mc_start with ex_mc_cycles=4 -> stall=001111 for 4 consecutive cycles, mc_busy=1 for 3, stall=0 on the 5th cycle.
REQ-035 Boundary: ex_mc_start with ex_mc_cycles=1 -> stall=0 and mc_busy never asserted; a start pulse during MC_BUSY does not extend the count.
REQ-036 Priority: mem_stallreq asserted in MC_BUSY cycle 2 of 5 -> stall=011111 during mem_stallreq, the counter still expires on schedule, and stall=0 after both clear.
REQ-037 Flush: branch_taken=1 with mem_stallreq=1 -> flush=0; when mem_stallreq drops -> flush=1 in that cycle; branch_taken with load-use -> flush=1 and stall=0.
REQ-038 Reset mid-operation: reset in MC_BUSY with mc_cnt=5 -> next cycle state=IDLE, mc_busy=0 and stall=0.
